// File: rtl/imm_gen_stage_if.sv
// Handshake bundle for imm_gen_stage: upstream decode fields in, extended immediate and target out.
// The stage itself connects through the slave modport; the producer/consumer side uses master.
interface imm_gen_stage_if #(
    parameter int XLEN   = 32,
    parameter int TYPE_W = 4
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [31:0]       INS;
    logic [TYPE_W-1:0] TYPE;
    logic [XLEN-1:0]   PC;
    logic              OUT_VALID;
    logic              OUT_READY;
    logic [XLEN-1:0]   IMM;
    logic [XLEN-1:0]   TARGET;
    logic              ILLEGAL;

    modport master (
        output IN_VALID, INS, TYPE, PC, OUT_READY,
        input  IN_READY, OUT_VALID, IMM, TARGET, ILLEGAL
    );

    modport slave (
        input  IN_VALID, INS, TYPE, PC, OUT_READY,
        output IN_READY, OUT_VALID, IMM, TARGET, ILLEGAL
    );
endinterface

// File: rtl/imm_gen_stage.sv
// Immediate-generation stage: decodes and extends the instruction immediate, adds it to PC,
// and buffers results in an output slot plus one skid entry behind a valid/ready handshake.
module imm_gen_stage #(
    parameter int XLEN    = 32,
    parameter int TYPE_W  = 4,
    parameter int REG_OUT = 1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    imm_gen_stage_if.slave  bus
);

    // Returns {illegal, imm}. Signed locals of the field's natural width sign-extend on the size cast.
    function automatic logic [XLEN:0] decode_f(input logic [31:7] ins, input logic [TYPE_W-1:0] typ);
        logic signed [11:0] i12;
        logic signed [11:0] s12;
        logic signed [12:0] b13;
        logic signed [31:0] u32;
        logic signed [20:0] j21;
        logic [XLEN-1:0]    imm;
        logic               ill;
        i12 = ins[31:20];
        s12 = {ins[31:25], ins[11:7]};
        b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        u32 = {ins[31:12], 12'b0};
        j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        imm = '0;
        ill = 1'b0;
        case (32'(typ))
            32'd0:   imm = '0;
            32'd1:   imm = XLEN'(i12);
            32'd2:   imm = XLEN'(s12);
            32'd3:   imm = XLEN'(b13);
            32'd4:   imm = XLEN'(u32);
            32'd5:   imm = XLEN'(j21);
            32'd6:   imm = XLEN'(ins[19:15]);
            32'd7:   imm = (XLEN == 64) ? XLEN'(ins[25:20]) : XLEN'(ins[24:20]);
            32'd8:   imm = '0;
            default: ill = 1'b1;
        endcase
        return {ill, imm};
    endfunction

    logic            unused_opcode;
    logic [XLEN:0]   dec_in;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_tgt;
    logic            in_ill;

    assign unused_opcode = ^bus.INS[6:0];
    assign dec_in        = decode_f(bus.INS[31:7], bus.TYPE);
    assign in_imm        = dec_in[XLEN-1:0];
    assign in_ill        = dec_in[XLEN];
    assign in_tgt        = bus.PC + in_imm;

    logic            out_vld_q, out_vld_d;
    logic [XLEN-1:0] out_imm_q, out_imm_d;
    logic [XLEN-1:0] out_tgt_q, out_tgt_d;
    logic            out_ill_q, out_ill_d;
    logic            skid_vld_q, skid_vld_d;
    logic [XLEN-1:0] skid_imm_q, skid_imm_d;
    logic [XLEN-1:0] skid_tgt_q, skid_tgt_d;
    logic            skid_ill_q, skid_ill_d;

    logic in_rdy;
    logic in_fire;
    logic bypass;
    logic byp_show;
    logic out_valid;
    logic out_fire;

    // Ready depends only on the skid register so upstream never sees a combinational path.
    assign in_rdy    = ~skid_vld_q;
    assign in_fire   = bus.IN_VALID & in_rdy;
    assign bypass    = (REG_OUT == 0) && !out_vld_q;
    assign byp_show  = bypass & bus.IN_VALID & RST_N & ~FLUSH;
    assign out_valid = out_vld_q | byp_show;
    assign out_fire  = out_valid & bus.OUT_READY;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_imm_d  = out_imm_q;
        out_tgt_d  = out_tgt_q;
        out_ill_d  = out_ill_q;
        skid_vld_d = skid_vld_q;
        skid_imm_d = skid_imm_q;
        skid_tgt_d = skid_tgt_q;
        skid_ill_d = skid_ill_q;
        if (FLUSH) begin
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!out_vld_q || out_fire) begin
            // Output slot frees up: the older skid entry has priority over the input.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_imm_d  = skid_imm_q;
                out_tgt_d  = skid_tgt_q;
                out_ill_d  = skid_ill_q;
                skid_vld_d = 1'b0;
            end else if (in_fire && !(bypass && bus.OUT_READY)) begin
                out_vld_d = 1'b1;
                out_imm_d = in_imm;
                out_tgt_d = in_tgt;
                out_ill_d = in_ill;
            end else begin
                out_vld_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_vld_d = 1'b1;
            skid_imm_d = in_imm;
            skid_tgt_d = in_tgt;
            skid_ill_d = in_ill;
        end
    end

    // Output slot / skid register boundary
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_vld_q  <= 1'b0;
            out_imm_q  <= '0;
            out_tgt_q  <= '0;
            out_ill_q  <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_imm_q <= '0;
            skid_tgt_q <= '0;
            skid_ill_q <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_imm_q  <= out_imm_d;
            out_tgt_q  <= out_tgt_d;
            out_ill_q  <= out_ill_d;
            skid_vld_q <= skid_vld_d;
            skid_imm_q <= skid_imm_d;
            skid_tgt_q <= skid_tgt_d;
            skid_ill_q <= skid_ill_d;
        end
    end

    assign bus.IN_READY  = in_rdy;
    assign bus.OUT_VALID = out_valid;
    assign bus.IMM       = byp_show ? in_imm : out_imm_q;
    assign bus.TARGET    = byp_show ? in_tgt : out_tgt_q;
    assign bus.ILLEGAL   = byp_show ? in_ill : out_ill_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: 32-bit and 64-bit registered instances plus a 32-bit bypass instance.
module tb_imm_gen_stage;

    logic clk;
    logic rst_n;
    logic flush;

    int n_chk;
    int n_bad;

    imm_gen_stage_if #(.XLEN(32), .TYPE_W(4)) b32 ();
    imm_gen_stage_if #(.XLEN(64), .TYPE_W(4)) b64 ();
    imm_gen_stage_if #(.XLEN(32), .TYPE_W(4)) b0 ();

    imm_gen_stage #(.XLEN(32), .TYPE_W(4), .REG_OUT(1)) u32 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .bus(b32.slave)
    );
    imm_gen_stage #(.XLEN(64), .TYPE_W(4), .REG_OUT(1)) u64 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .bus(b64.slave)
    );
    imm_gen_stage #(.XLEN(32), .TYPE_W(4), .REG_OUT(0)) u0 (
        .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .bus(b0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run32(input string tag, input logic [31:0] ins, input logic [3:0] typ,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] tgt,
                         input logic ill);
        b32.IN_VALID = 1'b1;
        b32.INS      = ins;
        b32.TYPE     = typ;
        b32.PC       = pc;
        chk({tag, "_rdy"}, 64'(b32.IN_READY), 64'd1);
        tick;
        chk({tag, "_vld"}, 64'(b32.OUT_VALID), 64'd1);
        chk({tag, "_imm"}, 64'(b32.IMM), 64'(imm));
        chk({tag, "_tgt"}, 64'(b32.TARGET), 64'(tgt));
        chk({tag, "_ill"}, 64'(b32.ILLEGAL), 64'(ill));
    endtask

    task automatic run64(input string tag, input logic [31:0] ins, input logic [3:0] typ,
                         input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] tgt);
        b64.IN_VALID = 1'b1;
        b64.INS      = ins;
        b64.TYPE     = typ;
        b64.PC       = pc;
        tick;
        chk({tag, "_vld"}, 64'(b64.OUT_VALID), 64'd1);
        chk({tag, "_imm"}, b64.IMM, imm);
        chk({tag, "_tgt"}, b64.TARGET, tgt);
    endtask

    initial begin
        int idx;
        int n_out;
        logic [31:0] seen [2];
        logic acc;

        n_chk = 0;
        n_bad = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        b32.IN_VALID = 1'b0; b32.INS = '0; b32.TYPE = '0; b32.PC = '0; b32.OUT_READY = 1'b1;
        b64.IN_VALID = 1'b0; b64.INS = '0; b64.TYPE = '0; b64.PC = '0; b64.OUT_READY = 1'b1;
        b0.IN_VALID  = 1'b0; b0.INS  = '0; b0.TYPE  = '0; b0.PC  = '0; b0.OUT_READY  = 1'b1;

        tick; tick;
        rst_n = 1'b1;
        tick;
        chk("rst_vld",  64'(b32.OUT_VALID), 64'd0);
        chk("rst_rdy",  64'(b32.IN_READY),  64'd1);
        chk("rst_imm",  64'(b32.IMM),       64'd0);
        chk("rst_tgt",  64'(b32.TARGET),    64'd0);
        chk("rst_ill",  64'(b32.ILLEGAL),   64'd0);
        chk("rst64_vld", 64'(b64.OUT_VALID), 64'd0);

        // back-to-back stream at full rate, one result per cycle
        run32("addi",  32'hFFF00093, 4'd1,  32'h100,      32'hFFFFFFFF, 32'h000000FF, 1'b0);
        run32("beq",   32'hFE000EE3, 4'd3,  32'h200,      32'hFFFFFFFC, 32'h000001FC, 1'b0);
        run32("jal",   32'h0080006F, 4'd5,  32'h300,      32'h00000008, 32'h00000308, 1'b0);
        run32("sw",    32'hFE000E23, 4'd2,  32'h10,       32'hFFFFFFFC, 32'h0000000C, 1'b0);
        run32("lui",   32'h800000B7, 4'd4,  32'h1000,     32'h80000000, 32'h80001000, 1'b0);
        run32("zimm",  32'h000F8073, 4'd6,  32'h0,        32'h0000001F, 32'h0000001F, 1'b0);
        run32("sh32",  32'h03F00013, 4'd7,  32'h0,        32'h0000001F, 32'h0000001F, 1'b0);
        run32("rtyp",  32'hFFFFFFFF, 4'd0,  32'h4,        32'h0,        32'h4,        1'b0);
        run32("ntyp",  32'hFFFFFFFF, 4'd8,  32'h8,        32'h0,        32'h8,        1'b0);
        run32("ill12", 32'hFFFFFFFF, 4'd12, 32'h40,       32'h0,        32'h40,       1'b1);
        run32("wrap",  32'h7FF00093, 4'd1,  32'hFFFFFFFF, 32'h000007FF, 32'h000007FE, 1'b0);
        b32.IN_VALID = 1'b0;
        tick;
        chk("drain_vld", 64'(b32.OUT_VALID), 64'd0);

        run64("lui64",  32'h800000B7, 4'd4, 64'h0, 64'hFFFFFFFF80000000, 64'hFFFFFFFF80000000);
        run64("sh64",   32'h03F00013, 4'd7, 64'h1000, 64'd63, 64'h103F);
        run64("addi64", 32'hFFF00093, 4'd1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        b64.IN_VALID = 1'b0;

        // back-pressure: offer 4 entries with the consumer stalled
        b32.OUT_READY = 1'b0;
        b32.TYPE = 4'd1;
        b32.PC = '0;
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            b32.IN_VALID = (idx <= 4);
            b32.INS = {idx[11:0], 20'h00093};
            acc = b32.IN_VALID & b32.IN_READY;
            tick;
            if (acc) idx++;
        end
        b32.IN_VALID = 1'b0;
        chk("bp_accepted", 64'(idx - 1), 64'd2);
        chk("bp_rdy_low",  64'(b32.IN_READY), 64'd0);
        chk("bp_head",     64'(b32.IMM), 64'd1);

        b32.OUT_READY = 1'b1;
        n_out = 0;
        for (int c = 0; c < 6; c++) begin
            if (b32.OUT_VALID) begin
                if (n_out < 2) seen[n_out] = b32.IMM;
                n_out++;
            end
            tick;
        end
        chk("bp_count", 64'(n_out), 64'd2);
        chk("bp_first", 64'(seen[0]), 64'd1);
        chk("bp_second", 64'(seen[1]), 64'd2);
        chk("bp_rdy_up", 64'(b32.IN_READY), 64'd1);

        // flush with both slots occupied and a new input on the bus
        b32.OUT_READY = 1'b0;
        b32.IN_VALID = 1'b1;
        b32.INS = 32'h00500093;
        tick;
        b32.INS = 32'h00600093;
        tick;
        chk("fl_full_rdy", 64'(b32.IN_READY), 64'd0);
        chk("fl_full_vld", 64'(b32.OUT_VALID), 64'd1);
        b32.INS = 32'h00700093;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        b32.IN_VALID = 1'b0;
        chk("fl_vld", 64'(b32.OUT_VALID), 64'd0);
        chk("fl_rdy", 64'(b32.IN_READY), 64'd1);
        b32.OUT_READY = 1'b1;
        n_out = 0;
        for (int c = 0; c < 3; c++) begin
            if (b32.OUT_VALID) n_out++;
            tick;
        end
        chk("fl_nothing", 64'(n_out), 64'd0);

        // input presented together with flush while ready is high is discarded
        b32.IN_VALID = 1'b1;
        b32.INS = 32'h00800093;
        flush = 1'b1;
        tick;
        flush = 1'b0;
        b32.IN_VALID = 1'b0;
        chk("fl_in_drop", 64'(b32.OUT_VALID), 64'd0);

        // asynchronous reset mid-stream
        b32.OUT_READY = 1'b0;
        b32.IN_VALID = 1'b1;
        b32.INS = 32'h00900093;
        b32.PC = 32'h50;
        tick;
        chk("ar_pre_vld", 64'(b32.OUT_VALID), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_vld_now", 64'(b32.OUT_VALID), 64'd0);
        chk("ar_imm_now", 64'(b32.IMM), 64'd0);
        chk("ar_tgt_now", 64'(b32.TARGET), 64'd0);
        b32.IN_VALID = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        chk("ar_rdy", 64'(b32.IN_READY), 64'd1);
        chk("ar_vld", 64'(b32.OUT_VALID), 64'd0);
        b32.OUT_READY = 1'b1;
        b32.IN_VALID = 1'b1;
        b32.INS = 32'h00A00093;
        b32.PC = 32'h60;
        #1;
        chk("ar_lat0", 64'(b32.OUT_VALID), 64'd0);
        tick;
        b32.IN_VALID = 1'b0;
        chk("ar_lat1_vld", 64'(b32.OUT_VALID), 64'd1);
        chk("ar_lat1_imm", 64'(b32.IMM), 64'd10);
        chk("ar_lat1_tgt", 64'(b32.TARGET), 64'h6A);

        // REG_OUT=0: combinational pass-through when empty, capture when stalled
        b0.IN_VALID = 1'b1;
        b0.INS = 32'hFFF00093;
        b0.TYPE = 4'd1;
        b0.PC = 32'h100;
        b0.OUT_READY = 1'b1;
        #1;
        chk("byp_vld", 64'(b0.OUT_VALID), 64'd1);
        chk("byp_imm", 64'(b0.IMM), 64'hFFFFFFFF);
        chk("byp_tgt", 64'(b0.TARGET), 64'hFF);
        tick;
        b0.OUT_READY = 1'b0;
        b0.INS = 32'hFE000EE3;
        b0.TYPE = 4'd3;
        b0.PC = 32'h200;
        tick;
        b0.IN_VALID = 1'b0;
        #1;
        chk("byp_hold_vld", 64'(b0.OUT_VALID), 64'd1);
        chk("byp_hold_imm", 64'(b0.IMM), 64'hFFFFFFFC);
        chk("byp_hold_tgt", 64'(b0.TARGET), 64'h1FC);
        b0.OUT_READY = 1'b1;
        tick;
        chk("byp_drain", 64'(b0.OUT_VALID), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered, parametrised immediate-generation stage between decode and execute.
- Extracts and extends the immediate from a 32-bit instruction word to XLEN bits, with more formats than the original combinational extender (CSR zimm, shift amount).
- Also computes the PC-relative target (PC + imm).
- Valid/ready handshake, 2-entry skid buffer for full throughput, synchronous flush.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- TYPE_W, 4, width of the immediate-type select.
- REG_OUT, 1, 1 = outputs driven from a register slice (latency 1); 0 = skid buffer only, outputs combinational from the head entry when bypassing.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- FLUSH  input  1  synchronous kill of all buffered entries.
- IN_VALID  input  1  upstream entry valid.
- IN_READY  output  1  stage can accept an entry this cycle.
- INS  input  32  instruction word; bits [6:0] ignored.
- TYPE  input  TYPE_W  immediate format select.
- PC  input  XLEN  PC of the instruction.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- IMM  output  XLEN  extended immediate.
- TARGET  output  XLEN  PC + IMM, modulo 2^XLEN.
- ILLEGAL  output  1  TYPE was an unassigned encoding.

Behaviour:
- TYPE encoding and result (s = INS[31] replicated to XLEN):
  - 0 R: 0.
  - 1 I: s:INS[30:20].
  - 2 S: s:INS[30:25]:INS[11:7].
  - 3 B: s:INS[7]:INS[30:25]:INS[11:8]:0.
  - 4 U: s above bit 31 : INS[31:12] : 12'b0. Sign-extended for XLEN=64.
  - 5 J: s:INS[19:12]:INS[20]:INS[30:21]:0.
  - 6 Z: zero-extended INS[19:15].
  - 7 SH: zero-extended INS[25:20] when XLEN=64; INS[24:20] when XLEN=32.
  - 8 N: 0.
  - 9-15: IMM = 0 and ILLEGAL = 1. ILLEGAL = 0 for types 0-8.
- TARGET = PC + IMM for every type, XLEN-bit add, carry discarded.
- Handshake:
  - Transfer in when IN_VALID && IN_READY.
  - Transfer out when OUT_VALID && OUT_READY.
  - OUT_VALID, once high, holds with IMM/TARGET/ILLEGAL stable until accepted.
- Buffering:
  - Output slot plus one skid entry.
  - IN_READY is a registered signal = skid entry empty.
  - With the output slot full and OUT_READY low, an input transfer goes to the skid entry and IN_READY drops next cycle.
  - When the output drains, skid contents move to the output slot and IN_READY rises next cycle.
  - No entry is ever dropped or duplicated; order is preserved.
- Latency:
  - REG_OUT=1: 1 cycle from input transfer to OUT_VALID. Throughput 1/cycle when OUT_READY is held high.
  - REG_OUT=0: output combinational from inputs when both slots are empty.
- Simultaneous in/out with output full, skid empty: output slot loads the new entry; skid stays empty.
- FLUSH:
  - Clears OUT_VALID and the skid entry next edge; IN_READY = 1 next cycle.
  - An input presented in the FLUSH cycle is discarded.
  - FLUSH overrides any simultaneous transfer.
- Reset (RST_N low, any time, including mid-transfer):
  - OUT_VALID = 0, IN_READY = 1 after release, skid empty, IMM = 0, TARGET = 0, ILLEGAL = 0.
  - Datapath registers are cleared too.
- Data registers load only on transfer, which minimises toggling.

Test Plan:
- XLEN=32, INS=32'hFFF00093 (addi x1,x0,-1), TYPE=1, PC=32'h100, OUT_READY=1 -> one cycle later OUT_VALID=1, IMM=32'hFFFFFFFF, TARGET=32'h000000FF.
- B-type INS=32'hFE000EE3 (beq x0,x0,-4), TYPE=3, PC=32'h200 -> IMM=32'hFFFFFFFC, TARGET=32'h1FC. J-type INS=32'h0080006F, TYPE=5 -> IMM=8.
- XLEN=64, INS=32'h800000B7 (lui x1,0x80000), TYPE=4 -> IMM=64'hFFFFFFFF80000000. TYPE=7 with INS[25:20]=6'h3F -> IMM=63.
- Back-pressure: stream 4 entries with OUT_READY=0 -> exactly 2 accepted, IN_READY low. Raise OUT_READY -> entries emerge in order, no loss or duplicate, then IN_READY rises.
- FLUSH with both slots full and IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, nothing emitted. TYPE=12 -> ILLEGAL=1, IMM=0.
- Assert RST_N=0 asynchronously mid-stream -> OUT_VALID drops immediately. After release IN_READY=1 and the first new entry appears after 1 cycle.
